// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbiter and its shifter datapath.
package shift_pkg;

    localparam int DATA_W = 32;
    localparam int AMT_W  = 5;

    localparam logic [1:0] SH_SRL = 2'b00;
    localparam logic [1:0] SH_SRA = 2'b01;
    localparam logic [1:0] SH_SLL = 2'b10;
    localparam logic [1:0] SH_ILL = 2'b11;

    // One shift request as presented to the shared datapath
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [1:0]        op;
        logic [AMT_W-1:0]  amt;
    } sh_req_t;

endpackage

// File: rtl/shift_arbiter_shifter.sv
// Purely combinational 32-bit shifter shared by both requesters.
// The illegal op passes data through; the arbiter flags it separately.
module shift_arbiter_shifter
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        op,
    input  logic [AMT_W-1:0]  amt,
    output logic [DATA_W-1:0] result
);

    // Select the shift flavour from the op code
    always_comb begin
        result = data;
        case (op)
            SH_SRL:  result = data >> amt;
            SH_SRA:  result = $signed(data) >>> amt;
            SH_SLL:  result = data << amt;
            default: result = data;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shifter between the execute-stage port (0)
// and the memory-alignment port (1). Results land in a one-entry output
// register tagged with the requester id; per-port saturating grant counters
// are kept for performance debug.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [DATA_W-1:0] r0_data,
    input  logic [1:0]        r0_op,
    input  logic [AMT_W-1:0]  r0_amt,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [DATA_W-1:0] r1_data,
    input  logic [1:0]        r1_op,
    input  logic [AMT_W-1:0]  r1_amt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_id,
    output logic [DATA_W-1:0] out_result,
    output logic              out_err,
    output logic [CNT_W-1:0]  gnt_cnt0,
    output logic [CNT_W-1:0]  gnt_cnt1
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic              last_grant;
    logic              can_accept;
    logic              gnt_valid;
    logic              gnt_id;
    logic              accept;
    sh_req_t           sel_req;
    logic [DATA_W-1:0] sh_result;
    logic [DATA_W-1:0] res_next;
    logic              err_next;

    assign can_accept = !out_valid || out_ready;

    // Pick a port: a lone requester wins, a tie goes to the port not served last
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        if (r0_valid && r1_valid) begin
            gnt_valid = 1'b1;
            gnt_id    = ~last_grant;
        end else if (r0_valid) begin
            gnt_valid = 1'b1;
            gnt_id    = 1'b0;
        end else if (r1_valid) begin
            gnt_valid = 1'b1;
            gnt_id    = 1'b1;
        end
    end

    assign accept   = can_accept && gnt_valid;
    assign r0_ready = accept && !gnt_id;
    assign r1_ready = accept && gnt_id;

    // Steer the granted port onto the single shifter input
    always_comb begin
        if (gnt_id) begin
            sel_req = '{data: r1_data, op: r1_op, amt: r1_amt};
        end else begin
            sel_req = '{data: r0_data, op: r0_op, amt: r0_amt};
        end
    end

    shift_arbiter_shifter u_shifter (
        .data   (sel_req.data),
        .op     (sel_req.op),
        .amt    (sel_req.amt),
        .result (sh_result)
    );

    // Illegal ops return the operand untouched and raise the error flag
    always_comb begin
        err_next = (sel_req.op == SH_ILL);
        res_next = err_next ? sel_req.data : sh_result;
    end

    // Output register: load on accept, drain on consume, otherwise hold
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_id     <= 1'b0;
            out_result <= '0;
            out_err    <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_id     <= gnt_id;
            out_result <= res_next;
            out_err    <= err_next;
            last_grant <= gnt_id;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // Per-port accept counters that stick at all-ones
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else if (accept) begin
            if (!gnt_id && gnt_cnt0 != CNT_MAX) begin
                gnt_cnt0 <= gnt_cnt0 + CNT_ONE;
            end
            if (gnt_id && gnt_cnt1 != CNT_MAX) begin
                gnt_cnt1 <= gnt_cnt1 + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_shift_arbiter;
    import shift_pkg::*;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              r0_valid = 1'b0, r1_valid = 1'b0;
    logic              r0_ready, r1_ready;
    logic [31:0]       r0_data = '0, r1_data = '0;
    logic [1:0]        r0_op = '0, r1_op = '0;
    logic [4:0]        r0_amt = '0, r1_amt = '0;
    logic              out_valid, out_ready = 1'b0;
    logic              out_id, out_err;
    logic [31:0]       out_result;
    logic [CNT_W-1:0]  gnt_cnt0, gnt_cnt1;

    shift_arbiter #(.CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .r0_valid   (r0_valid),
        .r0_ready   (r0_ready),
        .r0_data    (r0_data),
        .r0_op      (r0_op),
        .r0_amt     (r0_amt),
        .r1_valid   (r1_valid),
        .r1_ready   (r1_ready),
        .r1_data    (r1_data),
        .r1_op      (r1_op),
        .r1_amt     (r1_amt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_id     (out_id),
        .out_result (out_result),
        .out_err    (out_err),
        .gnt_cnt0   (gnt_cnt0),
        .gnt_cnt1   (gnt_cnt1)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    bit          m_valid;
    bit          m_id;
    logic [31:0] m_res;
    bit          m_err;
    int          m_cnt [2];
    bit          m_last;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Shift computed with integer arithmetic (division/multiplication by 2^amt)
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [1:0] op, input int amt);
        longint p, s, q;
        p = longint'(1) << amt;
        case (op)
            2'b00: q = longint'(d) / p;
            2'b01: begin
                s = longint'(d) - (d[31] ? 64'sh1_0000_0000 : 64'sh0);
                q = (s < 0) ? -((-s + p - 1) / p) : s / p;
            end
            2'b10: q = longint'(d) * p;
            default: q = longint'(d);
        endcase
        return q[31:0];
    endfunction

    task automatic model_reset();
        m_valid = 0; m_id = 0; m_res = '0; m_err = 0;
        m_cnt[0] = 0; m_cnt[1] = 0; m_last = 1;
    endtask

    // One clock: check readys before the edge, advance the model, check outputs after
    task automatic cycle(output bit acc, output bit gid);
        bit          can, gv;
        logic [31:0] d;
        logic [1:0]  op;
        int          amt;
        #1;
        can = !m_valid || out_ready;
        gv  = r0_valid || r1_valid;
        gid = (r0_valid && r1_valid) ? !m_last : !r0_valid;
        acc = can && gv;
        check_eq("r0_ready", 32'(r0_ready), 32'(acc && !gid));
        check_eq("r1_ready", 32'(r1_ready), 32'(acc && gid));
        d   = gid ? r1_data : r0_data;
        op  = gid ? r1_op : r0_op;
        amt = gid ? int'(r1_amt) : int'(r0_amt);
        @(posedge clock);
        if (acc) begin
            m_valid = 1;
            m_id    = gid;
            m_err   = (op == 2'b11);
            m_res   = ref_shift(d, op, amt);
            if (m_cnt[gid] < CNT_MAX) m_cnt[gid]++;
            m_last  = gid;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        @(negedge clock);
        check_eq("out_valid", 32'(out_valid), 32'(m_valid));
        check_eq("out_id", 32'(out_id), 32'(m_id));
        check_eq("out_result", out_result, m_res);
        check_eq("out_err", 32'(out_err), 32'(m_err));
        check_eq("gnt_cnt0", 32'(gnt_cnt0), 32'(m_cnt[0]));
        check_eq("gnt_cnt1", 32'(gnt_cnt1), 32'(m_cnt[1]));
    endtask

    // Asynchronous reset pulse between edges; state must clear before any clock
    task automatic mid_reset();
        reset_n = 1'b0;
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_result", out_result, 32'd0);
        check_eq("rst_gnt_cnt0", 32'(gnt_cnt0), 32'd0);
        check_eq("rst_gnt_cnt1", 32'(gnt_cnt1), 32'd0);
        model_reset();
        #1;
        reset_n = 1'b1;
    endtask

    task automatic rand_port(output logic v, output logic [31:0] d, output logic [1:0] op, output logic [4:0] amt);
        v  = ($urandom_range(0, 9) < 6);
        d  = $urandom;
        op = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 5))
            0:       amt = 5'd0;
            1:       amt = 5'd31;
            default: amt = 5'($urandom_range(0, 31));
        endcase
    endtask

    initial begin
        bit acc, gid;
        bit pend0, pend1;
        model_reset();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Reset state, idle cycle
        cycle(acc, gid);

        // Port 0 alone: arithmetic right shift
        r0_valid = 1; r0_data = 32'h8000_0001; r0_op = 2'b01; r0_amt = 5'd4;
        out_ready = 1;
        cycle(acc, gid);
        check_eq("sra_result", out_result, 32'hF800_0000);
        r0_valid = 0;
        cycle(acc, gid);

        // Both valid from reset: port 0 first, then port 1
        mid_reset();
        r0_valid = 1; r0_data = 32'h1;         r0_op = 2'b10; r0_amt = 5'd31;
        r1_valid = 1; r1_data = 32'hFFFF_FFFF; r1_op = 2'b00; r1_amt = 5'd28;
        cycle(acc, gid);
        check_eq("tie_first", out_result, 32'h8000_0000);
        cycle(acc, gid);
        check_eq("tie_second", out_result, 32'h0000_000F);

        // Backpressure with both ports valid, then release
        out_ready = 0;
        repeat (5) cycle(acc, gid);
        out_ready = 1;
        cycle(acc, gid);
        check_eq("bp_release_accept", 32'(acc), 32'd1);

        // Illegal op on port 1
        r0_valid = 0;
        r1_valid = 1; r1_data = 32'h1234_5678; r1_op = 2'b11; r1_amt = 5'd7;
        cycle(acc, gid);
        check_eq("ill_err", 32'(out_err), 32'd1);
        r1_valid = 0;

        // amt = 0 is identity for every legal op
        for (int op = 0; op < 3; op++) begin
            r0_valid = 1; r0_data = 32'hA5C3_0F81; r0_op = 2'(op); r0_amt = 5'd0;
            cycle(acc, gid);
        end
        r0_valid = 0;

        // Reset while a result is held, then a tie must go to port 0
        out_ready = 0;
        r0_valid = 1;
        cycle(acc, gid);
        mid_reset();
        out_ready = 1;
        r1_valid = 1; r1_op = 2'b00;
        cycle(acc, gid);
        check_eq("post_reset_tie_id", 32'(out_id), 32'd0);
        r0_valid = 0; r1_valid = 0;
        cycle(acc, gid);

        // Counter saturation on port 0
        mid_reset();
        r0_valid = 1;
        for (int i = 0; i < 20; i++) begin
            r0_data = $urandom; r0_op = 2'($urandom_range(0, 3)); r0_amt = 5'($urandom_range(0, 31));
            cycle(acc, gid);
        end
        check_eq("sat_cnt0", 32'(gnt_cnt0), 32'd15);
        check_eq("sat_cnt1", 32'(gnt_cnt1), 32'd0);
        r0_valid = 0;

        // Randomized traffic honouring hold-until-ready, with occasional drops
        mid_reset();
        pend0 = 0; pend1 = 0;
        for (int i = 0; i < 600; i++) begin
            if (!(pend0 && $urandom_range(0, 7) != 0))
                rand_port(r0_valid, r0_data, r0_op, r0_amt);
            if (!(pend1 && $urandom_range(0, 7) != 0))
                rand_port(r1_valid, r1_data, r1_op, r1_amt);
            out_ready = ($urandom_range(0, 9) < 7);
            cycle(acc, gid);
            pend0 = r0_valid && !(acc && !gid);
            pend1 = r1_valid && !(acc && gid);
            if (i % 150 == 149) begin
                mid_reset();
                pend0 = 0; pend1 = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares the single combinational Shifter datapath (32-bit data, 2-bit op, 5-bit amount) between two requesters. Port 0 is the execute-stage shift path and port 1 is the memory-alignment path. Uses round-robin grant, valid/ready handshakes and a one-entry registered result stage tagged with the requester id. Keeps per-port saturating grant counters for performance debug.

## Interface
- CNT_W, 16, width of each saturating grant counter
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- r0_valid / r1_valid  in  1  request pending on port 0 / port 1
- r0_ready / r1_ready  out  1  request accepted this cycle (combinational)
- r0_data / r1_data  in  32  operand
- r0_op / r1_op  in  2  00 logical right, 01 arithmetic right, 10 logical left, 11 illegal
- r0_amt / r1_amt  in  5  shift amount 0..31
- out_valid  out  1  result register holds a result
- out_ready  in  1  consumer accepts result
- out_id  out  1  requester that issued the result
- out_result  out  32  shifted value
- out_err  out  1  result came from an illegal op
- gnt_cnt0 / gnt_cnt1  out  CNT_W  saturating count of accepted requests per port

## Operation
- Accept window: can_accept = !out_valid | out_ready.
- Arbitration (combinational): only one valid port gets the grant. Both valid gives the grant to the port != last_grant.
- rN_ready = can_accept & grant==N. At most one ready is high per cycle.
- On accept: the granted port's data/op/amt drive the shared Shifter. The result, id and err are loaded into the output register, out_valid is set to 1, and last_grant is set to the granted port.
- Illegal op 11: out_result = data unchanged and out_err = 1. The Shifter result is ignored.
- Legal ops: out_err = 0. out_result matches data>>amt, $signed(data)>>>amt, or data<<amt.
- Consume without new accept (out_valid & out_ready & no grant): out_valid goes to 0. out_result, out_id and out_err hold their last values.
- While out_valid & !out_ready, the output register and all four out_* signals stay stable.
- Grant counters: gnt_cntN increments on each accept from port N and saturates at all-ones. It never wraps.
- A requester must hold valid/data/op/amt stable until ready. Dropping valid before ready is legal and does not corrupt state.

## Timing
- Reset values: out_valid=0, out_id=0, out_result=0, out_err=0, gnt_cnt0=0, gnt_cnt1=0, last_grant=1. With last_grant=1, port 0 wins the first tie after reset.
- Latency: accept at edge k gives out_valid=1 with the result after edge k.
- Throughput: 1 result per cycle while out_ready=1. Alternating ports under continuous contention.
- Same-cycle consume and accept: the register is overwritten and out_valid stays 1, with no bubble.
- Reset asserted mid-operation: all state clears immediately (asynchronously). Any in-flight result is dropped and is not replayed.
- amt=0 returns data unchanged for every legal op.

## Structure
- Package shift_pkg holds the op localparams: SH_SRL=2'b00, SH_SRA=2'b01, SH_SLL=2'b10, SH_ILL=2'b11. The Shifter and its bench share this package.
- Exactly one Shifter instance, muxed at its input by the grant. No duplicate datapath.
- Arbiter logic is small and stays inline, with no extra sub-module.

## Test plan
- Port 0 only: data=0x80000001, op=01, amt=4 -> one cycle after the accept, out_valid=1, out_id=0, out_result=0xF8000000, out_err=0, gnt_cnt0=1.
- Both ports valid from reset with out_ready=1: r0 (data=0x1, op=10, amt=31) and r1 (data=0xFFFFFFFF, op=00, amt=28) -> result 0x80000000 (id 0) then 0x0000000F (id 1) on consecutive cycles, never two readys in one cycle.
- Backpressure: hold out_ready=0 for 5 cycles with both ports valid -> r0_ready=r1_ready=0, and out_result/out_id stay frozen. When out_ready rises, exactly one new accept happens that cycle with no bubble.
- Illegal op: r1 data=0x12345678, op=11, amt=7 -> out_result=0x12345678, out_err=1, out_id=1, gnt_cnt1 increments.
- Reset mid-stream: pulse reset_n low between edges while out_valid=1 -> out_valid=0 and counters=0 at once. The next tie grants port 0.
- CNT_W=4: 20 back-to-back port-0 accepts -> gnt_cnt0 reaches 15 and holds at 15. gnt_cnt1 stays 0.
